// File: rtl/serial_tap_pkg.sv
// Shared types and sizing helpers for the serial tap detector.
package serial_tap_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Fill counter must be able to represent 0..DEPTH.
  function automatic int unsigned fill_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_tap_reg.sv
// DEPTH-deep serial shift register; taps[0] holds the newest accepted bit.
module shift_tap_reg #(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else if (in_valid) begin
      taps <= {taps[DEPTH-2:0], in_bit};
    end
  end

endmodule

// File: rtl/serial_tap_detector.sv
// Serial pattern detector: registered tap window, fill/run FSM, saturating
// match counter and a single-slot valid/ready match-event interface.
module serial_tap_detector
  import serial_tap_pkg::*;
#(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [DEPTH-1:0] pattern,
  input  logic             clear_cnt,
  output logic [DEPTH-1:0] taps,
  output logic             fill_done,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_seq,
  output logic             evt_overflow
);

  localparam int unsigned     FILL_W  = fill_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              fill_done_d;
  logic              match_d;
  logic [CNT_W-1:0]  match_cnt_d;
  logic              evt_valid_d;
  logic [CNT_W-1:0]  evt_seq_d;
  logic              evt_overflow_d;

  logic [DEPTH-1:0]  window_c;
  logic              fill_last_c;
  logic              hit_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [CNT_W-1:0]  cnt_post_c;

  shift_tap_reg #(
    .DEPTH (DEPTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .taps     (taps)
  );

  // Compare against the window as it will look after this bit is shifted in.
  assign window_c    = {taps[DEPTH-2:0], in_bit};
  assign fill_last_c = (fill_cnt_q == FILL_W'(DEPTH - 1));
  assign hit_c       = in_valid && ((state_q == ST_RUN) || fill_last_c) &&
                       (window_c == pattern);
  assign cnt_inc_c   = (match_cnt_q_eq_max()) ? match_cnt : match_cnt + CNT_W'(1);
  assign cnt_post_c  = clear_cnt ? '0 : cnt_inc_c;

  function automatic logic match_cnt_q_eq_max();
    return match_cnt == CNT_MAX;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      fill_cnt_q   <= '0;
      fill_done    <= 1'b0;
      match        <= 1'b0;
      match_cnt    <= '0;
      evt_valid    <= 1'b0;
      evt_seq      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_done    <= fill_done_d;
      match        <= match_d;
      match_cnt    <= match_cnt_d;
      evt_valid    <= evt_valid_d;
      evt_seq      <= evt_seq_d;
      evt_overflow <= evt_overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    fill_done_d    = fill_done;
    match_d        = hit_c;
    match_cnt_d    = match_cnt;
    evt_valid_d    = evt_valid;
    evt_seq_d      = evt_seq;
    evt_overflow_d = evt_overflow;

    if (in_valid) begin
      if (state_q == ST_FILL) begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
        if (fill_last_c) begin
          state_d     = ST_RUN;
          fill_done_d = 1'b1;
        end
      end
      // Non-overlapping mode discards the matched window's bits for detection.
      if (hit_c && (OVERLAP == 0)) begin
        state_d     = ST_FILL;
        fill_cnt_d  = '0;
        fill_done_d = 1'b0;
      end
    end

    if (clear_cnt) begin
      match_cnt_d = '0;
    end else if (hit_c) begin
      match_cnt_d = cnt_inc_c;
    end

    // Single event slot: load when free or being drained, else flag overflow.
    if (hit_c) begin
      if (!evt_valid || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_seq_d   = cnt_post_c;
      end else begin
        evt_overflow_d = 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (clear_cnt) begin
      evt_overflow_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tap_detector.sv
// Directed self-checking bench: overlap, non-overlap and 2-bit-counter
// instances share one stimulus stream.
module tb_serial_tap_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic [2:0] pattern;
  logic       clear_cnt;
  logic       evt_ready;

  logic [2:0] a_taps, b_taps, s_taps;
  logic       a_fill_done, b_fill_done, s_fill_done;
  logic       a_match, b_match, s_match;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] s_cnt;
  logic       a_evt_valid, b_evt_valid, s_evt_valid;
  logic [7:0] a_evt_seq, b_evt_seq;
  logic [1:0] s_evt_seq;
  logic       a_ovf, b_ovf, s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_tap_detector #(.DEPTH(3), .CNT_W(8), .OVERLAP(1)) u_ov1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .pattern(pattern),
    .clear_cnt(clear_cnt), .taps(a_taps), .fill_done(a_fill_done), .match(a_match),
    .match_cnt(a_cnt), .evt_valid(a_evt_valid), .evt_ready(evt_ready),
    .evt_seq(a_evt_seq), .evt_overflow(a_ovf)
  );

  serial_tap_detector #(.DEPTH(3), .CNT_W(8), .OVERLAP(0)) u_ov0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .pattern(pattern),
    .clear_cnt(clear_cnt), .taps(b_taps), .fill_done(b_fill_done), .match(b_match),
    .match_cnt(b_cnt), .evt_valid(b_evt_valid), .evt_ready(evt_ready),
    .evt_seq(b_evt_seq), .evt_overflow(b_ovf)
  );

  serial_tap_detector #(.DEPTH(3), .CNT_W(2), .OVERLAP(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .pattern(pattern),
    .clear_cnt(clear_cnt), .taps(s_taps), .fill_done(s_fill_done), .match(s_match),
    .match_cnt(s_cnt), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
    .evt_seq(s_evt_seq), .evt_overflow(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    logic [4:0] stream;
    logic [4:0] exp_m1, exp_m0, exp_fd1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    pattern   = 3'b101;
    clear_cnt = 1'b0;
    evt_ready = 1'b1;

    // Reset state of every instance
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_taps",  32'(a_taps), 32'd0);
    chk("rst_a_fd",    32'(a_fill_done), 32'd0);
    chk("rst_a_match", 32'(a_match), 32'd0);
    chk("rst_a_cnt",   32'(a_cnt), 32'd0);
    chk("rst_a_ev",    32'(a_evt_valid), 32'd0);
    chk("rst_a_seq",   32'(a_evt_seq), 32'd0);
    chk("rst_a_ovf",   32'(a_ovf), 32'd0);
    chk("rst_b_all",   32'({b_taps, b_fill_done, b_match, b_cnt, b_evt_valid, b_evt_seq, b_ovf}), 32'd0);
    chk("rst_s_all",   32'({s_taps, s_fill_done, s_match, s_cnt, s_evt_valid, s_evt_seq, s_ovf}), 32'd0);

    // Stream 1,0,1,0,1 against 101: overlap vs. non-overlap
    stream  = 5'b10101;
    exp_m1  = 5'b10100;
    exp_m0  = 5'b00100;
    exp_fd1 = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      push(stream[i]);
      chk($sformatf("t1_ov1_match[%0d]", i), 32'(a_match), 32'(exp_m1[i]));
      chk($sformatf("t1_ov0_match[%0d]", i), 32'(b_match), 32'(exp_m0[i]));
      chk($sformatf("t1_ov1_fd[%0d]", i), 32'(a_fill_done), 32'(exp_fd1[i]));
      chk($sformatf("t1_ov0_fd[%0d]", i), 32'(b_fill_done), 32'd0);
      if (i == 2) begin
        chk("t1_ov1_seq1",  32'(a_evt_seq), 32'd1);
        chk("t1_ov1_taps",  32'(a_taps), 32'h5);
        chk("t1_ov1_ev1",   32'(a_evt_valid), 32'd1);
      end
      if (i == 3) chk("t1_ov1_drain", 32'(a_evt_valid), 32'd0);
    end
    chk("t1_ov1_cnt", 32'(a_cnt), 32'd2);
    chk("t1_ov1_seq2", 32'(a_evt_seq), 32'd2);
    chk("t1_ov1_ev2", 32'(a_evt_valid), 32'd1);
    chk("t1_ov0_cnt", 32'(b_cnt), 32'd1);
    in_valid = 1'b0;

    // Gaps in in_valid freeze the window
    do_reset();
    push(1'b1);
    chk("t2_taps0", 32'(a_taps), 32'h1);
    in_valid = 1'b0;
    in_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_gap_taps[%0d]", i), 32'(a_taps), 32'h1);
      chk($sformatf("t2_gap_match[%0d]", i), 32'(a_match), 32'd0);
    end
    push(1'b0);
    chk("t2_taps1", 32'(a_taps), 32'h2);
    chk("t2_match1", 32'(a_match), 32'd0);
    push(1'b1);
    chk("t2_taps2", 32'(a_taps), 32'h5);
    chk("t2_match2", 32'(a_match), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("t2_match_end", 32'(a_match), 32'd0);
    chk("t2_cnt", 32'(a_cnt), 32'd1);

    // Blocked event slot, overflow, saturation and clear priority
    do_reset();
    pattern   = 3'b111;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1);
    chk("t3_cnt", 32'(a_cnt), 32'd3);
    chk("t3_seq", 32'(a_evt_seq), 32'd1);
    chk("t3_ev",  32'(a_evt_valid), 32'd1);
    chk("t3_ovf", 32'(a_ovf), 32'd1);
    chk("t3_s_cnt", 32'(s_cnt), 32'd3);
    in_valid  = 1'b0;
    evt_ready = 1'b1;
    tick();
    chk("t3_drain", 32'(a_evt_valid), 32'd0);
    chk("t3_ovf_sticky", 32'(a_ovf), 32'd1);
    push(1'b1);
    chk("t3_s_seq_sat", 32'(s_evt_seq), 32'd3);
    chk("t3_a_seq4", 32'(a_evt_seq), 32'd4);
    push(1'b1);
    chk("t3_a_cnt5", 32'(a_cnt), 32'd5);
    chk("t3_s_cnt_sat", 32'(s_cnt), 32'd3);
    clear_cnt = 1'b1;
    push(1'b1);
    clear_cnt = 1'b0;
    chk("t3_clr_match", 32'(a_match), 32'd1);
    chk("t3_clr_cnt", 32'(a_cnt), 32'd0);
    chk("t3_clr_ovf", 32'(a_ovf), 32'd0);
    chk("t3_clr_ev", 32'(a_evt_valid), 32'd1);
    chk("t3_clr_seq", 32'(a_evt_seq), 32'd0);
    chk("t3_clr_s_cnt", 32'(s_cnt), 32'd0);
    push(1'b1);
    chk("t3_after_clr_cnt", 32'(a_cnt), 32'd1);
    chk("t3_after_clr_seq", 32'(a_evt_seq), 32'd1);
    in_valid = 1'b0;

    // Reset mid-fill discards the partial window
    do_reset();
    pattern = 3'b101;
    push(1'b1);
    push(1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_taps", 32'(a_taps), 32'd0);
    chk("t4_rst_outs", 32'({a_fill_done, a_match, a_cnt, a_evt_valid, a_evt_seq, a_ovf}), 32'd0);
    push(1'b1);
    chk("t4_m1", 32'(a_match), 32'd0);
    chk("t4_taps1", 32'(a_taps), 32'h1);
    push(1'b0);
    chk("t4_m2", 32'(a_match), 32'd0);
    push(1'b1);
    chk("t4_m3", 32'(a_match), 32'd1);
    chk("t4_taps3", 32'(a_taps), 32'h5);
    chk("t4_cnt", 32'(a_cnt), 32'd1);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tap_detector.md
Name: serial_tap_detector

Overview:
Clocked serial-bit consumer placed directly downstream of the combinational a→b→c→d tap chain. It registers a 1-bit stream into a DEPTH-deep shift register and exposes the taps as stable registered signals. A fill/run state machine compares the taps against a programmable pattern and emits match pulses, a saturating match count and a valid/ready match-event handshake.

Parameters:
DEPTH, 3, number of shift stages and pattern width; legal range 2..16
CNT_W, 8, width of match counter and event sequence field
OVERLAP, 1, 1 = matches may share bits; 0 = refill DEPTH fresh bits after each match

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_bit is accepted on this cycle
in_bit  in  1  serial data bit (the chain's "a")
pattern  in  DEPTH  target window; bit 0 = newest bit
clear_cnt  in  1  synchronous clear of match_cnt and evt_overflow
taps  out  DEPTH  registered window; taps[0] newest, taps[DEPTH-1] oldest
fill_done  out  1  high once DEPTH bits are held since the last (re)fill
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  saturating count of matches
evt_valid  out  1  match event pending
evt_ready  in  1  consumer accepts event
evt_seq  out  CNT_W  match_cnt value captured for the pending event
evt_overflow  out  1  sticky: a match arrived while an event was still pending

Behaviour:
- Reset (rst=1 at an edge): taps=0, fill_done=0, match=0, match_cnt=0, evt_valid=0, evt_seq=0, evt_overflow=0, FSM=FILL, fill counter=0. Reset mid-stream discards all held bits. No partial window survives.
- Shift: on in_valid=1, taps <= {taps[DEPTH-2:0], in_bit}. The new bit appears on taps[0] one cycle after acceptance. With in_valid=0, taps, FSM and counters hold and match=0.
- FSM FILL: each accepted bit increments the fill counter. The bit that brings the count to DEPTH moves the FSM to RUN and sets fill_done on the same edge.
- FSM RUN: every accepted bit is compared.
- Compare rule: the next-window value {taps[DEPTH-2:0], in_bit} is compared with pattern, together with the completion condition (bit completes fill, or FSM already RUN). On equality, match=1 on the following cycle, aligned with the updated taps. pattern is sampled on the accepting cycle only.
- OVERLAP=0: a match forces FSM to FILL with the fill counter at 0 and fill_done=0 on the same edge. Taps keep their contents.
- OVERLAP=1: the FSM stays in RUN after a match.
- match_cnt: increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
- clear_cnt: forces match_cnt=0 and evt_overflow=0. clear_cnt coincident with a match leaves match_cnt=0; clear has priority. The match pulse and event still occur, with evt_seq=0.
- Event load: on a match, if evt_valid=0, or evt_valid=1 with evt_ready=1 on the same cycle, then evt_valid<=1 and evt_seq<=the post-increment match_cnt.
- Event overflow: if evt_valid=1 and evt_ready=0 when a match occurs, the pending event is kept unchanged and evt_overflow<=1.
- Event drain: evt_ready=1 with evt_valid=1 and no new match clears evt_valid next cycle. evt_valid and evt_seq stay stable until accepted.
- Latency: in_bit accepted at edge N appears on taps at N+1 and on match/match_cnt at N+1. evt_valid follows at N+1 when the event slot is free.

Decomposition:
- Package serial_tap_pkg: FSM state enum {FILL, RUN} and a fill-counter width constant, $clog2(DEPTH+1).
- Sub-module shift_tap_reg holds the DEPTH-wide shift register (clk, rst, in_valid, in_bit, taps).
- FSM, compare, counter and event handshake live in the top.

Test Plan:
- OVERLAP=1, DEPTH=3, pattern=3'b101, evt_ready=1; stream 1,0,1,0,1 with in_valid=1 every cycle -> match pulses after the 3rd and 5th bits; match_cnt=2; evt_seq values 1 then 2.
- OVERLAP=0, same stream -> one match, after the 3rd bit; fill_done drops to 0 and stays 0 through bits 4–5; match_cnt=1.
- Bit 1 with in_valid=1, then 3 cycles with in_valid=0, then bits 0,1 -> taps frozen during the gaps; exactly one match, 1 cycle after the final bit.
- evt_ready=0, pattern=3'b111, stream of five 1s, OVERLAP=1 -> match_cnt=3; evt_seq=1 held; evt_overflow=1. Then evt_ready=1 for 1 cycle -> evt_valid=0 next cycle.
- CNT_W=2, 5 matches -> match_cnt saturates at 3. clear_cnt on the same cycle as a match -> match_cnt=0, evt_overflow=0.
- rst asserted after 2 fill bits, then 1,0,1 -> no match before 3 new bits; taps=3'b101 at the match; all outputs 0 in the cycle after rst.
